// File: rtl/fir_pkg.sv
// Shared constants and helpers for the fir output stages.
package fir_pkg;

    localparam int FIR_RESULT_SZ = 33;
    localparam int FIR_OUT_SZ    = 16;
    localparam int SAT_MAX_SZ    = 64;

    // Sign-extend the low in_sz bits of v, then clamp to the signed out_sz-bit range.
    function automatic logic signed [SAT_MAX_SZ-1:0] saturate(
        input logic signed [SAT_MAX_SZ-1:0] v,
        input int                           in_sz,
        input int                           out_sz
    );
        logic signed [SAT_MAX_SZ-1:0] ext_v;
        logic signed [SAT_MAX_SZ-1:0] max_v;
        logic signed [SAT_MAX_SZ-1:0] min_v;
        logic signed [SAT_MAX_SZ-1:0] res_v;
        ext_v = v <<< (SAT_MAX_SZ - in_sz);
        ext_v = ext_v >>> (SAT_MAX_SZ - in_sz);
        max_v = (64'sd1 <<< (out_sz - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_sz - 1));
        if (ext_v > max_v) begin
            res_v = max_v;
        end else if (ext_v < min_v) begin
            res_v = min_v;
        end else begin
            res_v = ext_v;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// Sample stream from fir into the decimator and valid/ready result stream out of it.
interface fir_decim_out_if
    import fir_pkg::*;
#(
    parameter int IN_SZ  = FIR_RESULT_SZ,
    parameter int OUT_SZ = FIR_OUT_SZ
);
    logic signed [IN_SZ-1:0]  in;
    logic                     in_valid;
    logic signed [OUT_SZ-1:0] out;
    logic                     out_valid;
    logic                     out_ready;

    modport master (output in, in_valid, out_ready, input out, out_valid);
    modport slave  (input in, in_valid, out_ready, output out, out_valid);
endinterface

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is ignored unless a pop frees a slot.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Accept decisions: pop needs data, push needs room or a simultaneous pop.
    always_comb begin
        do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {(AW+1){1'b0}});
endmodule

// File: rtl/fir_decim_out.sv
// Decimating output stage for fir: keep 1 of DECIM samples, scale, saturate, buffer.
// Build option FIR_DECIM_ROUND_EN adds round-half-up before the right shift.
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int IN_SZ  = FIR_RESULT_SZ,
    parameter int OUT_SZ = FIR_OUT_SZ,
    parameter int SHIFT  = 15,
    parameter int DECIM  = 4,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    fir_decim_out_if.slave bus,
    output logic           sat_flag,
    output logic           ovf_flag,
    input  logic           clr_flags
);
    localparam int              PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
`ifdef FIR_DECIM_ROUND_EN
    localparam logic signed [IN_SZ:0] BIAS = {{IN_SZ{1'b0}}, 1'b1} << (SHIFT - 1);
`endif

    logic [PH_W-1:0]              ph_r;
    logic                         stage_valid_r;
    logic [OUT_SZ-1:0]            stage_data_r;
    logic [OUT_SZ-1:0]            last_r;
    logic                         sat_flag_r;
    logic                         ovf_flag_r;
    logic                         keep_s;
    logic signed [IN_SZ:0]        ext_s;
    logic signed [IN_SZ:0]        biased_s;
    logic signed [IN_SZ:0]        shifted_s;
    logic signed [SAT_MAX_SZ-1:0] wide_s;
    logic                         clip_s;
    logic [OUT_SZ-1:0]            scaled_s;
    logic [OUT_SZ-1:0]            head_s;
    logic                         full_s;
    logic                         empty_s;
    logic                         pop_s;
    logic                         ovf_s;

    // Keep decision and the scale/saturate datapath for the incoming sample.
    always_comb begin
        keep_s   = bus.in_valid && (ph_r == {PH_W{1'b0}});
        ext_s    = {bus.in[IN_SZ-1], bus.in};
`ifdef FIR_DECIM_ROUND_EN
        biased_s = ext_s + BIAS;
`else
        biased_s = ext_s;
`endif
        shifted_s = biased_s >>> SHIFT;
        wide_s    = SAT_MAX_SZ'(shifted_s);
        clip_s    = (saturate(wide_s, IN_SZ + 1, OUT_SZ) != wide_s);
        scaled_s  = OUT_SZ'(saturate(wide_s, IN_SZ + 1, OUT_SZ));
        pop_s     = !empty_s && bus.out_ready;
        // A drop only happens when the full FIFO is not also being drained this cycle.
        ovf_s     = stage_valid_r && full_s && !pop_s;
    end

    // Phase counter, stage register, held output value and sticky flags (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_r          <= {PH_W{1'b0}};
            stage_valid_r <= 1'b0;
            stage_data_r  <= {OUT_SZ{1'b0}};
            last_r        <= {OUT_SZ{1'b0}};
            sat_flag_r    <= 1'b0;
            ovf_flag_r    <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                ph_r <= (ph_r == PH_LAST) ? {PH_W{1'b0}} : ph_r + PH_W'(1);
            end
            stage_valid_r <= keep_s;
            if (keep_s) begin
                stage_data_r <= scaled_s;
            end
            if (pop_s) begin
                last_r <= head_s;
            end
            sat_flag_r <= (keep_s && clip_s) || (sat_flag_r && !clr_flags);
            ovf_flag_r <= ovf_s || (ovf_flag_r && !clr_flags);
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_SZ),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stage_valid_r),
        .push_data (stage_data_r),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign bus.out_valid = !empty_s;
    assign bus.out       = empty_s ? last_r : head_s;
    assign sat_flag      = sat_flag_r;
    assign ovf_flag      = ovf_flag_r;
endmodule

// File: tb/tb_fir_decim_out.sv
// Self-checking bench for fir_decim_out: vector table plus output scoreboard queue.
module tb_fir_decim_out;
    import fir_pkg::*;

    localparam int IN_SZ  = 33;
    localparam int OUT_SZ = 16;
`ifdef FIR_DECIM_ROUND_EN
    localparam int R = 1;
`else
    localparam int R = 0;
`endif
    localparam longint FILLER = 64'sd2147483648;

    typedef struct {
        longint din;
        longint exp_out;
        bit     exp_sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sat_flag;
    logic ovf_flag;
    logic clr_flags;

    vec_t   vecs [13];
    longint sb [$];
    int     n_vec = 0;
    int     n_err = 0;

    always #5 clk = ~clk;

    fir_decim_out_if #(.IN_SZ(IN_SZ), .OUT_SZ(OUT_SZ)) bus ();

    fir_decim_out #(
        .IN_SZ  (IN_SZ),
        .OUT_SZ (OUT_SZ),
        .SHIFT  (15),
        .DECIM  (4),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sat_flag  (sat_flag),
        .ovf_flag  (ovf_flag),
        .clr_flags (clr_flags)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: score any pop at the negedge, then step past the next rising edge.
    task automatic tick();
        longint e;
        @(negedge clk);
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got %0d, expected no output", $signed(bus.out));
            end else begin
                e = sb.pop_front();
                check("out_data", longint'($signed(bus.out)), e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit valid, input longint din);
        bus.in_valid = valid;
        bus.in       = IN_SZ'(din);
        tick();
    endtask

    task automatic fillers(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, FILLER);
        end
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        drive(1'b0, 64'sd0);
        clr_flags = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            tick();
        end
        tick();
        check("drain_empty", longint'(sb.size()), 64'sd0);
        check("drain_valid", longint'(bus.out_valid), 64'sd0);
    endtask

    initial begin
        vecs[0]  = '{64'sd3293184,     64'sd100 + R,  1'b0};
        vecs[1]  = '{-64'sd32768,      -64'sd1,       1'b0};
        vecs[2]  = '{64'sd2147483648,  64'sd32767,    1'b1};
        vecs[3]  = '{-64'sd2147483648, -64'sd32768,   1'b1};
        vecs[4]  = '{64'sd163840,      64'sd5,        1'b0};
        vecs[5]  = '{64'sd16384,       64'sd0 + R,    1'b0};
        vecs[6]  = '{-64'sd16384,      -64'sd1 + R,   1'b0};
        vecs[7]  = '{64'sd1073709056,  64'sd32767,    1'b0};
        vecs[8]  = '{64'sd1073741824,  64'sd32767,    1'b1};
        vecs[9]  = '{-64'sd1073741824, -64'sd32768,   1'b0};
        vecs[10] = '{-64'sd1073774592, -64'sd32768,   1'b1};
        vecs[11] = '{64'sd4294967295,  64'sd32767,    1'b1};
        vecs[12] = '{-64'sd4294967296, -64'sd32768,   1'b1};

        rst           = 1'b1;
        clr_flags     = 1'b0;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", longint'(bus.out_valid), 64'sd0);
        check("rst_out", longint'($signed(bus.out)), 64'sd0);
        check("rst_sat", longint'(sat_flag), 64'sd0);
        check("rst_ovf", longint'(ovf_flag), 64'sd0);
        rst = 1'b0;

        // Table: one kept sample followed by three saturating fillers that must be skipped.
        for (int v = 0; v < 13; v++) begin
            pulse_clr();
            sb.push_back(vecs[v].exp_out);
            drive(1'b1, vecs[v].din);
            fillers(3);
            drain();
            check("vec_sat", longint'(sat_flag), longint'(vecs[v].exp_sat));
            check("vec_ovf", longint'(ovf_flag), 64'sd0);
        end
        pulse_clr();
        check("clr_sat", longint'(sat_flag), 64'sd0);

        // Decimation ordering.
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 0) begin
                sb.push_back(longint'(k));
            end
            drive(1'b1, longint'(k) * 64'sd32768);
        end
        drain();
        check("decim_sat", longint'(sat_flag), 64'sd0);

        // Backpressure and overrun: six kept samples into a 4-deep FIFO.
        pulse_clr();
        bus.out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            if (v <= 4) begin
                sb.push_back(longint'(v));
            end
            drive(1'b1, longint'(v) * 64'sd32768);
            fillers(3);
        end
        drive(1'b0, 64'sd0);
        check("ovr_ovf", longint'(ovf_flag), 64'sd1);
        check("ovr_valid", longint'(bus.out_valid), 64'sd1);
        check("ovr_head", longint'($signed(bus.out)), 64'sd1);
        drain();
        check("ovr_hold", longint'($signed(bus.out)), 64'sd4);
        check("ovr_sat", longint'(sat_flag), 64'sd0);

        // Full FIFO with push and pop landing on the same edge.
        pulse_clr();
        bus.out_ready = 1'b0;
        for (int v = 11; v <= 14; v++) begin
            sb.push_back(longint'(v));
            drive(1'b1, longint'(v) * 64'sd32768);
            fillers(3);
        end
        check("full_no_ovf", longint'(ovf_flag), 64'sd0);
        sb.push_back(64'sd15);
        drive(1'b1, 64'sd15 * 64'sd32768);
        bus.out_ready = 1'b1;
        drive(1'b1, FILLER);
        bus.out_ready = 1'b0;
        fillers(2);
        check("pp_ovf", longint'(ovf_flag), 64'sd0);
        check("pp_head", longint'($signed(bus.out)), 64'sd12);
        drain();

        // A set event in the same cycle as clr_flags wins.
        sb.push_back(64'sd32767);
        clr_flags = 1'b1;
        drive(1'b1, FILLER);
        clr_flags = 1'b0;
        check("set_wins_sat", longint'(sat_flag), 64'sd1);
        fillers(3);
        drain();

        // Reset with three entries buffered and phase at 2.
        pulse_clr();
        bus.out_ready = 1'b0;
        drive(1'b1, 64'sd21 * 64'sd32768);
        fillers(3);
        drive(1'b1, 64'sd22 * 64'sd32768);
        fillers(3);
        drive(1'b1, 64'sd23 * 64'sd32768);
        fillers(1);
        check("pre_rst_valid", longint'(bus.out_valid), 64'sd1);
        rst = 1'b1;
        drive(1'b0, 64'sd0);
        rst = 1'b0;
        check("mid_rst_valid", longint'(bus.out_valid), 64'sd0);
        check("mid_rst_out", longint'($signed(bus.out)), 64'sd0);
        sb.push_back(64'sd77);
        drive(1'b1, 64'sd77 * 64'sd32768);
        check("lat1_valid", longint'(bus.out_valid), 64'sd0);
        drive(1'b0, 64'sd0);
        check("lat2_valid", longint'(bus.out_valid), 64'sd1);
        check("lat2_out", longint'($signed(bus.out)), 64'sd77);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
